// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: main register plus one skid entry, valid/ready on both sides,
// flush-to-bubble, occupancy output and a saturating stall counter.
module pipe_stage_elastic #(
  parameter int DATA_W      = 32,
  parameter bit BUBBLE_ZERO = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              m_valid_q, m_valid_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              in_fire, out_fire;

  // in_ready comes straight from the skid flag, so out_ready never reaches it combinationally
  assign in_fire  = in_valid & ~s_valid_q;
  assign out_fire = m_valid_q & out_ready;

  always_comb begin
    m_valid_d   = m_valid_q;
    s_valid_d   = s_valid_q;
    m_data_d    = m_data_q;
    s_data_d    = s_data_q;
    stall_cnt_d = stall_cnt_q;

    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      if (BUBBLE_ZERO) begin
        m_data_d = '0;
        s_data_d = '0;
      end
    end else if (!m_valid_q || out_fire) begin
      if (s_valid_q) begin
        m_data_d  = s_data_q;
        m_valid_d = 1'b1;
        s_valid_d = 1'b0;
      end else if (in_fire) begin
        m_data_d  = in_data;
        m_valid_d = 1'b1;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      s_data_d  = in_data;
      s_valid_d = 1'b1;
    end

    if (cnt_clr) begin
      stall_cnt_d = '0;
    end else if (m_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      m_valid_q   <= 1'b0;
      s_valid_q   <= 1'b0;
      m_data_q    <= '0;
      s_data_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      m_valid_q   <= m_valid_d;
      s_valid_q   <= s_valid_d;
      m_data_q    <= m_data_d;
      s_data_q    <= s_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign in_ready  = ~s_valid_q;
  assign out_valid = m_valid_q;
  assign out_data  = (BUBBLE_ZERO && !m_valid_q) ? '0 : m_data_q;
  assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: two instances (bubble-zero/16-bit counter and
// hold-data/2-bit counter) share stimulus and are checked every cycle against a queue model.
module tb_pipe_stage_elastic;

  logic        clk = 1'b0;
  logic        rst_n, iv, ordy, fl, clr;
  logic [31:0] id;

  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [31:0] a_out_data, b_out_data;
  logic [1:0]  a_occ, b_occ;
  logic [15:0] a_cnt;
  logic [1:0]  b_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.DATA_W(32), .BUBBLE_ZERO(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(rst_n), .in_valid(iv), .in_ready(a_in_ready), .in_data(id),
    .out_valid(a_out_valid), .out_ready(ordy), .out_data(a_out_data), .flush(fl),
    .occupancy(a_occ), .cnt_clr(clr), .stall_cnt(a_cnt));

  pipe_stage_elastic #(.DATA_W(32), .BUBBLE_ZERO(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .reset(rst_n), .in_valid(iv), .in_ready(b_in_ready), .in_data(id),
    .out_valid(b_out_valid), .out_ready(ordy), .out_data(b_out_data), .flush(fl),
    .occupancy(b_occ), .cnt_clr(clr), .stall_cnt(b_cnt));

  // Model: the stage is a FIFO of at most two payloads; the head is what the output shows.
  logic [31:0] q[$];
  logic [31:0] shown_a = '0, shown_b = '0;
  int          cnt_a = 0, cnt_b = 0;

  always @(posedge clk) begin
    int pre_size;
    pre_size = q.size();
    if (!rst_n) begin
      q.delete();
      shown_a = '0;
      shown_b = '0;
      cnt_a   = 0;
      cnt_b   = 0;
    end else begin
      if (clr) begin
        cnt_a = 0;
        cnt_b = 0;
      end else if (pre_size > 0 && !ordy) begin
        if (cnt_a < 65535) cnt_a++;
        if (cnt_b < 3)     cnt_b++;
      end
      if (fl) begin
        q.delete();
        shown_a = '0;
      end else begin
        if (ordy && pre_size > 0) void'(q.pop_front());
        if (iv && pre_size < 2) q.push_back(id);
        if (q.size() > 0) begin
          shown_a = q[0];
          shown_b = q[0];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a.out_valid", 64'(a_out_valid), 64'(q.size() > 0));
      chk("b.out_valid", 64'(b_out_valid), 64'(q.size() > 0));
      chk("a.in_ready",  64'(a_in_ready),  64'(q.size() < 2));
      chk("b.in_ready",  64'(b_in_ready),  64'(q.size() < 2));
      chk("a.occupancy", 64'(a_occ),       64'(q.size()));
      chk("b.occupancy", 64'(b_occ),       64'(q.size()));
      chk("a.out_data",  64'(a_out_data),  64'((q.size() > 0) ? q[0] : 32'h0));
      chk("b.out_data",  64'(b_out_data),  64'((q.size() > 0) ? q[0] : shown_b));
      chk("a.stall_cnt", 64'(a_cnt),       64'(cnt_a));
      chk("b.stall_cnt", 64'(b_cnt),       64'(cnt_b));
    end
  end

  // Apply one cycle of inputs; returns just after the following falling edge.
  task automatic step(input logic r, input logic v, input logic [31:0] d,
                      input logic o, input logic f, input logic c);
    rst_n = r; iv = v; id = d; ordy = o; fl = f; clr = c;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; iv = 1'b0; id = '0; ordy = 1'b1; fl = 1'b0; clr = 1'b0;
    @(negedge clk);
    #1;

    // 1: reset ignores inputs, then one transfer with single-cycle latency
    step(0, 1, 32'hDEADBEEF, 1, 0, 0);
    chk_en = 1'b1;
    step(0, 1, 32'hDEADBEEF, 1, 0, 0);
    chk("t1.out_valid", 64'(a_out_valid), 64'd0);
    chk("t1.out_data",  64'(a_out_data),  64'd0);
    chk("t1.in_ready",  64'(a_in_ready),  64'd1);
    chk("t1.occupancy", 64'(a_occ),       64'd0);
    step(1, 1, 32'h1, 1, 0, 0);
    chk("t1.first_valid", 64'(a_out_valid), 64'd1);
    chk("t1.first_data",  64'(a_out_data),  64'h1);
    step(1, 0, 32'h0, 1, 0, 0);

    // 2: streaming at full rate
    step(1, 1, 32'h10, 1, 0, 0);
    chk("t2.d0", 64'(a_out_data), 64'h10);
    step(1, 1, 32'h11, 1, 0, 0);
    chk("t2.d1", 64'(a_out_data), 64'h11);
    step(1, 1, 32'h12, 1, 0, 0);
    chk("t2.d2", 64'(a_out_data), 64'h12);
    chk("t2.occ", 64'(a_occ), 64'd1);
    chk("t2.in_ready", 64'(a_in_ready), 64'd1);
    step(1, 0, 32'h0, 1, 0, 0);
    chk("t2.stall_cnt", 64'(a_cnt), 64'd0);

    // 3: skid fill under stall, then in-order drain
    step(1, 0, 32'h0, 1, 0, 1);
    step(1, 1, 32'hA, 0, 0, 0);
    step(1, 1, 32'hB, 0, 0, 0);
    step(1, 1, 32'hC, 0, 0, 0);
    step(1, 1, 32'hC, 0, 0, 0);
    chk("t3.occ_full", 64'(a_occ), 64'd2);
    chk("t3.in_ready", 64'(a_in_ready), 64'd0);
    chk("t3.head", 64'(a_out_data), 64'hA);
    chk("t3.cnt_stall", 64'(a_cnt), 64'd3);
    step(1, 1, 32'hC, 1, 0, 0);
    chk("t3.second", 64'(a_out_data), 64'hB);
    step(1, 1, 32'hC, 1, 0, 0);
    chk("t3.third", 64'(a_out_data), 64'hC);
    step(1, 0, 32'h0, 1, 0, 0);
    chk("t3.drained", 64'(a_out_valid), 64'd0);
    chk("t3.cnt_final", 64'(a_cnt), 64'd3);

    // 4: flush while full discards everything, including the offered payload
    step(1, 1, 32'hA1, 0, 0, 1);
    step(1, 1, 32'hA2, 0, 0, 0);
    step(1, 1, 32'hF0, 0, 1, 0);
    chk("t4.out_valid", 64'(a_out_valid), 64'd0);
    chk("t4.out_data",  64'(a_out_data),  64'd0);
    chk("t4.occ",       64'(a_occ),       64'd0);
    chk("t4.in_ready",  64'(a_in_ready),  64'd1);
    chk("t4.hold_data", 64'(b_out_data),  64'hA1);
    step(1, 0, 32'h0, 1, 0, 0);
    chk("t4.no_f0", 64'(a_out_valid), 64'd0);
    step(1, 1, 32'h55, 0, 0, 0);
    step(1, 1, 32'hF1, 1, 1, 0);
    chk("t4.fire_killed", 64'(a_occ), 64'd0);
    step(1, 0, 32'h0, 1, 0, 0);

    // 5: reset dominates flush
    step(1, 1, 32'h21, 0, 0, 0);
    step(1, 1, 32'h22, 0, 0, 0);
    step(0, 1, 32'h23, 0, 1, 0);
    chk("t5.occ", 64'(a_occ), 64'd0);
    chk("t5.cnt", 64'(a_cnt), 64'd0);
    chk("t5.b_data", 64'(b_out_data), 64'd0);

    // 6: narrow counter saturates; clear wins over increment
    step(1, 1, 32'h31, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 32'h0, 0, 0, 0);
    chk("t6.sat_b", 64'(b_cnt), 64'd3);
    chk("t6.wide_a", 64'(a_cnt), 64'd5);
    step(1, 0, 32'h0, 0, 0, 1);
    chk("t6.clr_b", 64'(b_cnt), 64'd0);
    chk("t6.clr_a", 64'(a_cnt), 64'd0);
    step(1, 0, 32'h0, 1, 0, 0);
    step(1, 0, 32'h0, 1, 0, 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Parametrised successor to the fixed-field stage registers between pipeline stages. It carries one opaque payload bus per stage with a valid/ready handshake and a 2-entry skid buffer, so stalls need no combinational ready path back through the stage. It provides flush (bubble insertion), occupancy reporting and a saturating stall counter. It is instantiated between any two stages (F/D, D/E, E/M, M/W), with the stage's fields concatenated into data.

Parameters:
DATA_W, 32, payload width in bits (>=1)
BUBBLE_ZERO, 1, 1: out_data forced to 0 whenever out_valid=0; 0: out_data shows main register contents regardless
CNT_W, 16, stall counter width (>=2)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-low; reset==0 at a rising edge resets all state
in_valid  in  1  upstream presents a payload
in_ready  out  1  stage can accept; registered, equals !skid_valid
in_data  in  DATA_W  upstream payload
out_valid  out  1  main register holds a live payload
out_ready  in  1  downstream accepts this cycle
out_data  out  DATA_W  main register payload, or 0 per BUBBLE_ZERO
flush  in  1  kill all held payloads and any payload accepted this cycle
occupancy  out  2  live entries: 0, 1 or 2
cnt_clr  in  1  synchronous clear of stall_cnt
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- State: main register (m_valid, m_data) and skid register (s_valid, s_data).
- Fires: in_fire = in_valid & in_ready; out_fire = m_valid & out_ready.
- Priority per edge: reset > flush > normal update.
- Reset (reset==0): m_valid=0, s_valid=0, m_data=0, s_data=0, stall_cnt=0.
  - Resulting outputs: out_valid=0, out_data=0, in_ready=1, occupancy=0.
  - Inputs sampled in the reset cycle are ignored.
- Flush (reset==1, flush==1): m_valid=0, s_valid=0.
  - If BUBBLE_ZERO=1, data registers clear to 0; otherwise they hold.
  - in_fire in the same cycle is discarded, and in_ready is still 1 the next cycle.
  - out_fire in the same cycle still counts as consumed by downstream.
  - stall_cnt is unaffected by flush.
- Normal update, main register free (m_valid==0 or out_fire):
  - s_valid=1: m <= s, s_valid <= 0.
  - else if in_fire: m <= in_data, m_valid <= 1.
  - else: m_valid <= 0.
- Normal update, main register blocked (m_valid==1 and !out_fire):
  - if in_fire: s <= in_data, s_valid <= 1.
  - m holds.
- in_fire while s_valid=1 cannot occur, because in_ready=0.
- Order is strictly FIFO; no payload is ever dropped except by flush.
- Latency: empty stage with in_fire at edge N gives out_valid=1 with that data after edge N.
- Throughput: 1 payload/cycle when out_ready is held 1.
- occupancy = m_valid + s_valid. Value 2 implies in_ready=0.
- out_data = m_data when m_valid=1. When m_valid=0 it is 0 if BUBBLE_ZERO=1, else m_data.
- stall_cnt update:
  - cnt_clr=1 sets it to 0 (priority over increment).
  - else increments by 1 when m_valid & !out_ready, holding at 2^CNT_W-1.
  - It counts in flush cycles too; the condition is evaluated on pre-edge state.
- No combinational path from out_ready to in_ready. out_valid and out_data are registered, except for the BUBBLE_ZERO mux on out_data.

Test Plan:
1. Reset/deassert: hold reset=0 for 2 cycles with in_valid=1, data=0xDEADBEEF -> out_valid=0, out_data=0, in_ready=1, occupancy=0. After release, one in_fire of 0x1 -> next cycle out_valid=1, out_data=0x1.
2. Streaming: out_ready=1, feed 0x10,0x11,0x12 on consecutive cycles -> out_data 0x10,0x11,0x12 on the following three cycles, in_ready stays 1, occupancy=1, stall_cnt=0.
3. Skid/stall:
   - Hold out_ready=0, feed 0xA then 0xB -> occupancy=2, in_ready=0, 0xC held upstream.
   - Release out_ready -> 0xA, 0xB, 0xC delivered in order; stall_cnt equals the stalled cycles (e.g. 3).
4. Flush full: occupancy=2 with in_valid=1, data=0xF0 -> assert flush one cycle -> next cycle out_valid=0, out_data=0 (BUBBLE_ZERO=1), occupancy=0, in_ready=1; 0xF0 never appears at the output.
5. Flush vs reset: reset=0 and flush=1 together while full -> all state reset, stall_cnt=0.
6. Counter: with CNT_W=2, stall for 5 cycles -> stall_cnt=3 (saturated). Then cnt_clr=1 together with a stall condition -> stall_cnt=0.
